irq_timer_ctrl: RTL and testbench

Interrupt source block feeding the core's 4-bit `interrupt` input. It combines a reloadable down-counting machine timer and a synchronized external interrupt line, and latches each event as pending. It presents one prioritized request at a time and holds it stable until the core acknowledges trap entry. Further requests are masked until the core signals `mret`.

---
 rtl/irq_timer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_irq_timer_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_ctrl.sv
// ---------------------------------------------------------------------------
// irq_timer_ctrl
//
// Interrupt source block for the core's 4-bit `interrupt` input. Two event
// sources are latched as pending bits:
//   - a reloadable down-counting machine timer
//   - an asynchronous external line (synchronized, rising-edge detected)
// One prioritized request is presented at a time. It is held stable until
// the core acknowledges trap entry. Further requests are then masked until
// the core retires `mret`.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   timer_en     in   timer decrements while high
//   reload_wr    in   loads reload register and counter from reload_data
//   reload_data  in   [TIMER_WIDTH] new reload value
//   ext_inter    in   asynchronous external request; only its rising edge counts
//   int_ack      in   one-cycle pulse when the core takes the presented trap
//   is_mret      in   one-cycle pulse when the core retires mret
//   interrupt    out  [4] registered request code (0000 none, 0001 timer, 0010 ext)
//   busy         out  trap in service
//   timer_count  out  [TIMER_WIDTH] current counter value
// ---------------------------------------------------------------------------
module irq_timer_ctrl #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   timer_en,
    input  logic                   reload_wr,
    input  logic [TIMER_WIDTH-1:0] reload_data,
    input  logic                   ext_inter,
    input  logic                   int_ack,
    input  logic                   is_mret,
    output logic [3:0]             interrupt,
    output logic                   busy,
    output logic [TIMER_WIDTH-1:0] timer_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] CODE_NONE  = 4'b0000;
    localparam logic [3:0] CODE_TIMER = 4'b0001;
    localparam logic [3:0] CODE_EXT   = 4'b0010;

    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // External line: SYNC_STAGES-deep synchronizer plus one edge-detect flop
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_prev_q;
    logic                   ext_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            ext_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_inter};
            ext_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ext_rise = sync_q[SYNC_STAGES-1] & ~ext_prev_q;

    // -----------------------------------------------------------------------
    // Machine timer
    // -----------------------------------------------------------------------
    logic [TIMER_WIDTH-1:0] reload_reg;
    logic [TIMER_WIDTH-1:0] count;
    logic                   timer_fire;

    // A reload write takes the cycle, so it suppresses the underflow event.
    assign timer_fire = timer_en & ~reload_wr & (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_reg <= '1;
            count      <= '1;
        end else if (reload_wr) begin
            reload_reg <= reload_data;
            count      <= reload_data;
        end else if (timer_en) begin
            if (count == '0) begin
                count <= reload_reg;
            end else begin
                count <= count - TIMER_ONE;
            end
        end
    end

    assign timer_count = count;

    // -----------------------------------------------------------------------
    // Request FSM
    // -----------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] code_q;
    logic [3:0] code_d;
    logic       timer_pending_q;
    logic       ext_pending_q;
    logic       clr_timer;
    logic       clr_ext;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        clr_timer = 1'b0;
        clr_ext   = 1'b0;
        case (state_q)
            IDLE: begin
                // Timer has priority over the external line.
                if (timer_pending_q) begin
                    code_d  = CODE_TIMER;
                    state_d = REQ;
                end else if (ext_pending_q) begin
                    code_d  = CODE_EXT;
                    state_d = REQ;
                end
            end
            REQ: begin
                // The latched code is held until the ack; no preemption.
                if (int_ack) begin
                    clr_timer = (code_q == CODE_TIMER);
                    clr_ext   = (code_q == CODE_EXT);
                    code_d    = CODE_NONE;
                    state_d   = SERVICE;
                end
            end
            SERVICE: begin
                if (is_mret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                code_d  = CODE_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // A new event in the same cycle as the clear wins, so nothing is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_pending_q <= 1'b0;
            ext_pending_q   <= 1'b0;
        end else begin
            timer_pending_q <= timer_fire | (timer_pending_q & ~clr_timer);
            ext_pending_q   <= ext_rise   | (ext_pending_q   & ~clr_ext);
        end
    end

    assign interrupt = code_q;
    assign busy      = (state_q == SERVICE);

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_timer_ctrl
//
// Directed stimulus pushes hand-computed expected outputs, tagged with the
// cycle they are due, into a scoreboard queue. An independent monitor
// compares the DUT outputs against each entry when its cycle comes up.
// ---------------------------------------------------------------------------
module tb_irq_timer_ctrl;

    localparam int unsigned TW = 4;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          timer_en    = 1'b0;
    logic          reload_wr   = 1'b0;
    logic [TW-1:0] reload_data = '0;
    logic          ext_inter   = 1'b0;
    logic          int_ack     = 1'b0;
    logic          is_mret     = 1'b0;
    logic [3:0]    interrupt;
    logic          busy;
    logic [TW-1:0] timer_count;

    int unsigned cyc    = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        done    = 1'b0;

    typedef struct {
        int unsigned   at;
        string         name;
        logic [3:0]    irq;
        logic          bsy;
        logic          chk;
        logic [TW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    irq_timer_ctrl #(
        .TIMER_WIDTH(TW),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_en   (timer_en),
        .reload_wr  (reload_wr),
        .reload_data(reload_data),
        .ext_inter  (ext_inter),
        .int_ack    (int_ack),
        .is_mret    (is_mret),
        .interrupt  (interrupt),
        .busy       (busy),
        .timer_count(timer_count)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Expectation due after `dly` more rising edges.
    task automatic push_exp(input int unsigned dly, input string name,
                            input logic [3:0] irq, input logic bsy,
                            input logic chk, input logic [TW-1:0] cnt);
        exp_t e;
        e.at   = cyc + dly;
        e.name = name;
        e.irq  = irq;
        e.bsy  = bsy;
        e.chk  = chk;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
                if (done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s never compared: due cycle %0d, now %0d",
                             sb[i].name, sb[i].at, cyc);
                    sb.delete(i);
                end else if (sb[i].at == cyc) begin
                    n_tests++;
                    if (interrupt !== sb[i].irq || busy !== sb[i].bsy ||
                        (sb[i].chk && timer_count !== sb[i].cnt)) begin
                        n_fail++;
                        $display("FAIL %s cycle %0d: got interrupt=%b busy=%b count=%h, want interrupt=%b busy=%b count=%h (count checked=%b)",
                                 sb[i].name, cyc, interrupt, busy, timer_count,
                                 sb[i].irq, sb[i].bsy, sb[i].cnt, sb[i].chk);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset
        tick(1);
        push_exp(1, "rst_hold", 4'b0000, 1'b0, 1'b1, 4'hF);
        tick(1);
        rst = 1'b0;
        push_exp(1, "rst_idle", 4'b0000, 1'b0, 1'b1, 4'hF);
        tick(1);

        // T1: reload 3, count 3,2,1,0,3 then timer request
        reload_wr = 1'b1; reload_data = 4'd3; timer_en = 1'b1;
        push_exp(1, "t1_load",   4'b0000, 1'b0, 1'b1, 4'd3);
        push_exp(2, "t1_cnt2",   4'b0000, 1'b0, 1'b1, 4'd2);
        push_exp(3, "t1_cnt1",   4'b0000, 1'b0, 1'b1, 4'd1);
        push_exp(4, "t1_cnt0",   4'b0000, 1'b0, 1'b1, 4'd0);
        push_exp(5, "t1_reload", 4'b0000, 1'b0, 1'b1, 4'd3);
        push_exp(6, "t1_req",    4'b0001, 1'b0, 1'b1, 4'd3);
        tick(1);
        reload_wr = 1'b0;
        tick(4);
        timer_en = 1'b0;
        tick(1);
        int_ack = 1'b1;
        push_exp(1, "t1_ack", 4'b0000, 1'b1, 1'b1, 4'd3);
        tick(1);
        // ack held into SERVICE must be ignored
        push_exp(1, "t1_svc", 4'b0000, 1'b1, 1'b1, 4'd3);
        tick(1);
        int_ack = 1'b0; is_mret = 1'b1;
        push_exp(1, "t1_mret", 4'b0000, 1'b0, 1'b1, 4'd3);
        push_exp(2, "t1_idle", 4'b0000, 1'b0, 1'b1, 4'd3);
        tick(1);
        is_mret = 1'b0;
        tick(2);

        // T2: external latency, held line gives a single request
        ext_inter = 1'b1;
        push_exp(3, "t2_lat3", 4'b0000, 1'b0, 1'b0, 4'd0);
        push_exp(4, "t2_req",  4'b0010, 1'b0, 1'b0, 4'd0);
        tick(4);
        int_ack = 1'b1;
        push_exp(1, "t2_ack", 4'b0000, 1'b1, 1'b0, 4'd0);
        tick(1);
        int_ack = 1'b0; is_mret = 1'b1;
        push_exp(1, "t2_mret", 4'b0000, 1'b0, 1'b0, 4'd0);
        tick(1);
        is_mret = 1'b0;
        push_exp(1, "t2_norq1", 4'b0000, 1'b0, 1'b0, 4'd0);
        push_exp(4, "t2_norq4", 4'b0000, 1'b0, 1'b0, 4'd0);
        tick(4);
        ext_inter = 1'b0;
        tick(4);

        // T3: both pending at the same edge, timer first, ext after mret
        reload_wr = 1'b1; reload_data = 4'd1; timer_en = 1'b1; ext_inter = 1'b1;
        push_exp(3, "t3_both",  4'b0000, 1'b0, 1'b1, 4'd1);
        push_exp(4, "t3_timer", 4'b0001, 1'b0, 1'b1, 4'd1);
        tick(1);
        reload_wr = 1'b0;
        tick(2);
        timer_en = 1'b0;
        tick(1);
        int_ack = 1'b1;
        push_exp(1, "t3_ack", 4'b0000, 1'b1, 1'b1, 4'd1);
        tick(1);
        int_ack = 1'b0; is_mret = 1'b1;
        push_exp(1, "t3_mret", 4'b0000, 1'b0, 1'b1, 4'd1);
        push_exp(2, "t3_ext",  4'b0010, 1'b0, 1'b1, 4'd1);
        tick(1);
        is_mret = 1'b0;
        tick(1);

        // T4: REQ(0010) held for 20 cycles while the timer fires
        timer_en = 1'b1;
        for (int unsigned k = 1; k <= 20; k++) begin
            push_exp(k, "t4_hold", 4'b0010, 1'b0, 1'b0, 4'd0);
        end
        tick(20);
        timer_en = 1'b0; int_ack = 1'b1;
        push_exp(1, "t4_ack", 4'b0000, 1'b1, 1'b0, 4'd0);
        tick(1);
        int_ack = 1'b0; is_mret = 1'b1;
        push_exp(1, "t4_mret",  4'b0000, 1'b0, 1'b0, 4'd0);
        push_exp(2, "t4_tmr",   4'b0001, 1'b0, 1'b0, 4'd0);
        tick(1);
        is_mret = 1'b0; ext_inter = 1'b0;
        tick(1);

        // T5: reset in SERVICE with both sources pending
        int_ack = 1'b1;
        push_exp(1, "t5_ack", 4'b0000, 1'b1, 1'b0, 4'd0);
        tick(1);
        int_ack = 1'b0; reload_wr = 1'b1; reload_data = 4'd0; timer_en = 1'b1;
        tick(1);
        reload_wr = 1'b0; ext_inter = 1'b1;
        tick(2);
        push_exp(1, "t5_svc", 4'b0000, 1'b1, 1'b1, 4'd0);
        tick(1);
        rst = 1'b1; reload_wr = 1'b1; reload_data = 4'd5;
        int_ack = 1'b1; is_mret = 1'b1; timer_en = 1'b0; ext_inter = 1'b0;
        push_exp(1, "t5_rst", 4'b0000, 1'b0, 1'b1, 4'hF);
        tick(1);
        rst = 1'b0; reload_wr = 1'b0; int_ack = 1'b0; is_mret = 1'b0; reload_data = 4'd0;
        push_exp(1, "t5_idle1", 4'b0000, 1'b0, 1'b1, 4'hF);
        push_exp(4, "t5_idle4", 4'b0000, 1'b0, 1'b1, 4'hF);
        tick(5);

        // T6: reload 0 fires every cycle; event in the ack cycle stays pending
        reload_wr = 1'b1; reload_data = 4'd0; timer_en = 1'b1;
        push_exp(2, "t6_pend", 4'b0000, 1'b0, 1'b1, 4'd0);
        push_exp(3, "t6_req",  4'b0001, 1'b0, 1'b1, 4'd0);
        tick(1);
        reload_wr = 1'b0;
        tick(2);
        int_ack = 1'b1;
        push_exp(1, "t6_ack", 4'b0000, 1'b1, 1'b1, 4'd0);
        tick(1);
        int_ack = 1'b0; timer_en = 1'b0; is_mret = 1'b1;
        push_exp(1, "t6_mret",  4'b0000, 1'b0, 1'b1, 4'd0);
        push_exp(2, "t6_again", 4'b0001, 1'b0, 1'b1, 4'd0);
        tick(1);
        is_mret = 1'b0;
        tick(1);
        // mret outside SERVICE is ignored
        is_mret = 1'b1;
        push_exp(1, "t6_mret_ign", 4'b0001, 1'b0, 1'b1, 4'd0);
        tick(1);
        is_mret = 1'b0;
        push_exp(1, "t6_hold", 4'b0001, 1'b0, 1'b1, 4'd0);
        tick(3);

        #2 done = 1'b1;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
